rx: RTL and testbench

- UART receiver that directly consumes the serial line driven by the existing `tx` transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Idle line is 1.
- Block detects the start bit, samples each bit at mid-bit, checks the stop bit, then presents the byte with a one-cycle valid pulse.
- Downstream consumers (display, loopback checker) read `data_out` on `data_valid`.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/rx.sv | 144 ++++++++++++++
 tb/tb_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Framing constants and receiver state encoding shared by the UART rx and tx ends.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_DATA  = DATA,
        ST_STOP  = STOP,
        ST_BREAK = BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line, resetting to the idle level.
// Only compiled when RX_SYNC_EN is defined; the default build has no use for it.
`ifdef RX_SYNC_EN
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= IDLE_LVL;
            sync_q <= IDLE_LVL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule
`endif

// File: rtl/rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-cycle data_valid / frame_err pulses.
// Define RX_SYNC_EN to pass rx_in through a 2-flop synchronizer (adds 2 cycles of latency).
module rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

`ifdef RX_SYNC_EN
    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (rx_in),
        .dout  (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    rx_state_e     state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_s == START_LVL) begin
                    // With HALF=0 the detection cycle already is the mid-start sample.
                    if (HALF == '0) begin
                        state_d   = ST_DATA;
                        clk_cnt_d = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = ST_START;
                        clk_cnt_d = CW'(1);
                    end
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = (rx_s == START_LVL) ? ST_DATA : ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == LAST) begin
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == STOP_LVL) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start can be seen.
                if (rx_s == IDLE_LVL) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rx.sv
// Bench for rx: one instance at 1 clock/bit, one at 4 clocks/bit, driven like tx (on negedge).
module tb_rx;
  import uart_pkg::*;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT1 = 9 * 1 + 0 + 1 + SYNC_LAT;
  localparam int LAT4 = 9 * 4 + 1 + 1 + SYNC_LAT;

  logic clock;
  logic reset;
  logic rx1, rx4;
  logic [7:0] dout1, dout4;
  logic dv1, dv4, fe1, fe4, busy1, busy4;
  logic [2:0] st1, st4;

  int checks;
  int errors;
  int cyc;
  int nvalid1, nvalid4, nferr1, nferr4;
  int vprev4, vlast4;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q4[$];
  int st_q1[$];
  int st_q4[$];

  typedef struct {
    int sel;
    logic [7:0] din;
    int gap;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[8];

  rx #(.CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset), .rx_in(rx1), .data_out(dout1),
    .data_valid(dv1), .frame_err(fe1), .busy(busy1), .state_dbg(st1)
  );

  rx #(.CLKS_PER_BIT(4)) dut4 (
    .clock(clock), .reset(reset), .rx_in(rx4), .data_out(dout4),
    .data_valid(dv4), .frame_err(fe4), .busy(busy4), .state_dbg(st4)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one serial bit, held for the instance's bit time, starting at a negedge
  task automatic drive_bit(input int sel, input logic v);
    if (sel == 1) begin
      rx1 = v;
      @(negedge clock);
    end else begin
      rx4 = v;
      repeat (4) @(negedge clock);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_bit,
                            input logic [7:0] exp_b);
    if (stop_bit == STOP_LVL) begin
      if (sel == 1) begin
        exp_q1.push_back(exp_b);
        st_q1.push_back(cyc + 1);
      end else begin
        exp_q4.push_back(exp_b);
        st_q4.push_back(cyc + 1);
      end
    end
    drive_bit(sel, START_LVL);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
    drive_bit(sel, stop_bit);
  endtask

  // scoreboard: pop expectation whenever a data_valid pulse is seen
  task automatic monitor();
    logic [7:0] e;
    int s;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dv1) begin
          nvalid1++;
          if (exp_q1.size() == 0) check("dut1 unexpected data_valid", exp_q1.size(), 1);
          else begin
            e = exp_q1.pop_front();
            s = st_q1.pop_front();
            check("dut1 data_out", dout1, e);
            check("dut1 latency", cyc - s + 1, LAT1);
          end
        end
        if (dv4) begin
          nvalid4++;
          vprev4 = vlast4;
          vlast4 = cyc;
          if (exp_q4.size() == 0) check("dut4 unexpected data_valid", exp_q4.size(), 1);
          else begin
            e = exp_q4.pop_front();
            s = st_q4.pop_front();
            check("dut4 data_out", dout4, e);
            check("dut4 latency", cyc - s + 1, LAT4);
          end
        end
        if (fe1) nferr1++;
        if (fe4) nferr4++;
        if (dv1 || fe1) check("dut1 valid/ferr exclusive", dv1 & fe1, 0);
        if (dv4 || fe4) check("dut4 valid/ferr exclusive", dv4 & fe4, 0);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q1.size() + exp_q4.size()) != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("drain pending frames", exp_q1.size() + exp_q4.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int bcnt;
    int nv_snap, nf_snap;
    logic [7:0] d_snap;
    logic [7:0] rb;

    checks = 0; errors = 0;
    nvalid1 = 0; nvalid4 = 0; nferr1 = 0; nferr4 = 0;
    vprev4 = 0; vlast4 = 0;
    rx1 = 1'b1; rx4 = 1'b1;
    reset = 1'b1;

    rb = 8'($urandom_range(0, 255));
    vecs[0] = '{sel: 1, din: 8'hA5, gap: 3, exp_dout: 8'hA5};
    vecs[1] = '{sel: 1, din: 8'h00, gap: 0, exp_dout: 8'h00};
    vecs[2] = '{sel: 1, din: 8'hFF, gap: 2, exp_dout: 8'hFF};
    vecs[3] = '{sel: 1, din: 8'h5A, gap: 0, exp_dout: 8'h5A};
    vecs[4] = '{sel: 1, din: 8'h81, gap: 5, exp_dout: 8'h81};
    vecs[5] = '{sel: 4, din: 8'hC6, gap: 0, exp_dout: 8'hC6};
    vecs[6] = '{sel: 4, din: 8'h01, gap: 4, exp_dout: 8'h01};
    vecs[7] = '{sel: 1, din: rb,    gap: 1, exp_dout: rb};

    repeat (2) @(negedge clock);
    check("reset dut1 data_out", dout1, 0);
    check("reset dut1 data_valid", dv1, 0);
    check("reset dut1 frame_err", fe1, 0);
    check("reset dut1 busy", busy1, 0);
    check("reset dut1 state", st1, IDLE);
    check("reset dut4 data_out", dout4, 0);
    check("reset dut4 data_valid", dv4, 0);
    check("reset dut4 frame_err", fe4, 0);
    check("reset dut4 busy", busy4, 0);
    check("reset dut4 state", st4, IDLE);

    fork monitor(); join_none
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // table-driven frames (first entry is the A5 loopback case)
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].sel, vecs[i].din, STOP_LVL, vecs[i].exp_dout);
      repeat (vecs[i].gap) @(negedge clock);
    end
    drain();
    check("dut1 valid count", nvalid1, 6);
    check("dut4 valid count", nvalid4, 2);

    // back-to-back 3C, FF with zero idle gap
    send_frame(4, 8'h3C, STOP_LVL, 8'h3C);
    send_frame(4, 8'hFF, STOP_LVL, 8'hFF);
    drain();
    check("b2b pulse spacing", vlast4 - vprev4, 40);
    check("b2b final data_out", dout4, 8'hFF);
    check("b2b valid count", nvalid4, 4);

    // one-cycle glitch on idle line
    nv_snap = nvalid4; nf_snap = nferr4; d_snap = dout4; bcnt = 0;
    rx4 = 1'b0;
    @(negedge clock);
    bcnt += int'(busy4);
    rx4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      bcnt += int'(busy4);
    end
    check("glitch busy seen", bcnt >= 1, 1);
    check("glitch busy short", bcnt <= 2, 1);
    check("glitch back to idle", st4, IDLE);
    check("glitch no valid", nvalid4 - nv_snap, 0);
    check("glitch no frame_err", nferr4 - nf_snap, 0);
    check("glitch data_out kept", dout4, d_snap);

    // bad stop bit, then line held low as a break
    nv_snap = nvalid4; nf_snap = nferr4; d_snap = dout4;
    send_frame(4, 8'h81, 1'b0, 8'h00);
    rx4 = 1'b0;
    repeat (20) @(negedge clock);
    check("break frame_err once", nferr4 - nf_snap, 1);
    check("break data_out kept", dout4, d_snap);
    check("break held in BREAK", st4, BREAK);
    check("break busy", busy4, 1);
    check("break no valid", nvalid4 - nv_snap, 0);
    rx4 = 1'b1;
    repeat (4) @(negedge clock);
    check("break released idle", st4, IDLE);
    send_frame(4, 8'h55, STOP_LVL, 8'h55);
    repeat (2) @(negedge clock);
    drain();
    check("after break data_out", dout4, 8'h55);

    // asynchronous reset in the middle of data bit 4 of C3
    nv_snap = nvalid4;
    drive_bit(4, START_LVL);
    for (int i = 0; i < 4; i++) drive_bit(4, 1'(8'hC3 >> i));
    rx4 = 1'(8'hC3 >> 4);
    repeat (2) @(negedge clock);
    check("pre-reset busy", busy4, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset data_out", dout4, 0);
    check("async reset data_valid", dv4, 0);
    check("async reset frame_err", fe4, 0);
    check("async reset busy", busy4, 0);
    check("async reset state", st4, IDLE);
    @(negedge clock);
    rx4 = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("post-reset no valid", nvalid4 - nv_snap, 0);
    check("post-reset idle", busy4, 0);
    send_frame(4, 8'h12, STOP_LVL, 8'h12);
    repeat (2) @(negedge clock);
    drain();
    check("post-reset frame", dout4, 8'h12);

    check("dut1 never frame_err", nferr1, 0);
    check("dut4 frame_err total", nferr4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
